// File: rtl/ram_loader_if.sv
// Stream, control and read-port bundle for ram_loader.
// The master side drives the stream and controls; the slave side is the loader itself.
interface ram_loader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   length;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH:0]   wr_count;
  logic [DATA_WIDTH-1:0] checksum;

  modport master (
    output start, base_addr, length, in_valid, in_data, read_addr,
    input  in_ready, read_data, busy, done, wr_count, checksum
  );

  modport slave (
    input  start, base_addr, length, in_valid, in_data, read_addr,
    output in_ready, read_data, busy, done, wr_count, checksum
  );
endinterface

// File: rtl/ram_loader.sv
// Run-time loader for a small combinational-read lookup RAM: writes a valid/ready stream
// to consecutive addresses. Define RAM_LOADER_CHECKSUM_EN to add the running checksum.
module ram_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic         clk,
  input  logic         rst,
  ram_loader_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH:0]   len;
  logic [ADDR_WIDTH:0]   wr_count_r;
  logic                  in_ready_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // A request longer than the array would overwrite its own first words.
  function automatic logic [ADDR_WIDTH:0] clamp_len(input logic [ADDR_WIDTH:0] l);
    return (l > DEPTH_L) ? DEPTH_L : l;
  endfunction

  // Reset wins over a word presented on the same edge.
  assign xfer = in_ready_r && bus.in_valid && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      wr_count_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            cur_addr   <= bus.base_addr;
            len        <= clamp_len(bus.length);
            wr_count_r <= '0;
            busy_r     <= 1'b1;
            if (clamp_len(bus.length) == '0) begin
              state  <= DONE;
              done_r <= 1'b1;
            end else begin
              state      <= LOAD;
              in_ready_r <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            cur_addr   <= cur_addr + 1'b1;
            wr_count_r <= wr_count_r + ONE_L;
            if (wr_count_r + ONE_L == len) begin
              state      <= DONE;
              in_ready_r <= 1'b0;
              done_r     <= 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          in_ready_r <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

  // Storage is deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (xfer) mem[cur_addr] <= bus.in_data;
  end

  assign bus.read_data = mem[bus.read_addr];
  assign bus.in_ready  = in_ready_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.wr_count  = wr_count_r;

`ifdef RAM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_r <= '0;
    end else if (state == IDLE && bus.start) begin
      checksum_r <= '0;
    end else if (xfer) begin
      checksum_r <= checksum_r + bus.in_data;
    end
  end

  assign bus.checksum = checksum_r;
`else
  assign bus.checksum = '0;
`endif
endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: load table plus hand sequences and random loads,
// checked every cycle against a transaction-level model of the loader.
module tb_ram_loader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_loader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();
  ram_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec  = 0;
  int n_fail = 0;
  int done_seen;

  // Reference model: a load is "active" while words remain, "finishing" for the done cycle.
  bit       m_ok = 0;
  bit       m_active, m_done;
  int       m_len, m_addr, m_cnt;
  logic [7:0] m_sum;
  logic [7:0] m_mem [8];
  bit       m_known [8];

  typedef struct {
    logic [2:0]  base;
    logic [3:0]  len;
    logic [63:0] data;
    logic [3:0]  exp_writes;
    logic [7:0]  exp_sum;
    logic [2:0]  chk_addr;
    logic [7:0]  chk_data;
  } vec_t;
  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_checksum();
`ifdef RAM_LOADER_CHECKSUM_EN
    return m_sum;
`else
    return 8'h00;
`endif
  endfunction

  task automatic model_step();
    if (rst) begin
      m_ok = 1; m_active = 0; m_done = 0; m_cnt = 0; m_sum = 8'h00;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_active) begin
      if (bus.in_valid) begin
        m_mem[m_addr]   = bus.in_data;
        m_known[m_addr] = 1;
        m_addr = (m_addr + 1) % 8;
        m_cnt++;
        m_sum = m_sum + bus.in_data;
        if (m_cnt == m_len) begin
          m_active = 0;
          m_done   = 1;
        end
      end
    end else if (bus.start) begin
      m_len  = (int'(bus.length) > 8) ? 8 : int'(bus.length);
      m_addr = int'(bus.base_addr);
      m_cnt  = 0;
      m_sum  = 8'h00;
      if (m_len == 0) m_done = 1;
      else            m_active = 1;
    end
  endtask

  task automatic check_outputs();
    if (!m_ok) return;
    if (bus.done === 1'b1) done_seen++;
    chk("busy",     32'(bus.busy),     32'(m_active | m_done));
    chk("done",     32'(bus.done),     32'(m_done));
    chk("in_ready", 32'(bus.in_ready), 32'(m_active));
    chk("wr_count", 32'(bus.wr_count), 32'(m_cnt));
    chk("checksum", 32'(bus.checksum), 32'(exp_checksum()));
    if (m_known[bus.read_addr])
      chk("read_data", 32'(bus.read_data), 32'(m_mem[bus.read_addr]));
  endtask

  task automatic tick();
    bus.read_addr = 3'($urandom_range(0, 7));
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic run_load(input logic [2:0] base, input logic [3:0] len,
                          input logic [63:0] data, input int gap, input bit mid);
    int budget;
    done_seen     = 0;
    bus.base_addr = base;
    bus.length    = len;
    bus.in_valid  = 1'b0;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    budget = 200;
    while ((m_active || m_done) && budget > 0) begin
      bus.in_valid = ($urandom_range(0, 99) >= gap);
      bus.in_data  = data[8*(m_cnt % 8) +: 8];
      if (mid && $urandom_range(0, 3) == 0) begin
        bus.start     = 1'b1;
        bus.base_addr = 3'($urandom_range(0, 7));
        bus.length    = 4'($urandom_range(0, 15));
      end
      tick();
      bus.start = 1'b0;
      budget--;
    end
    bus.in_valid = 1'b0;
    if (budget == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL load_timeout: load still busy after 200 cycles, required to finish");
    end
  endtask

  initial begin
    vecs[0] = '{3'd0, 4'd4,  64'h0000_0000_4433_2211, 4'd4, 8'hAA, 3'd3, 8'h44};
    vecs[1] = '{3'd6, 4'd3,  64'h0000_0000_00A3_A2A1, 4'd3, 8'hE6, 3'd0, 8'hA3};
    vecs[2] = '{3'd5, 4'd0,  64'h0000_0000_0000_0000, 4'd0, 8'h00, 3'd0, 8'hA3};
    vecs[3] = '{3'd0, 4'd15, 64'h0807_0605_0403_0201, 4'd8, 8'h24, 3'd7, 8'h08};

    for (int i = 0; i < 8; i++) m_known[i] = 0;
    bus.start = 1'b1; bus.base_addr = '0; bus.length = 4'd3;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.read_addr = '0;
    rst = 1'b1;
    tick();
    tick();
    chk("reset_busy",     32'(bus.busy),     32'd0);
    chk("reset_done",     32'(bus.done),     32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
    chk("reset_wr_count", 32'(bus.wr_count), 32'd0);
    chk("reset_checksum", 32'(bus.checksum), 32'd0);
    rst = 1'b0;
    bus.start = 1'b0;
    tick();

    for (int v = 0; v < 4; v++) begin
      run_load(vecs[v].base, vecs[v].len, vecs[v].data, 0, 0);
      chk("tbl_wr_count", 32'(bus.wr_count), 32'(vecs[v].exp_writes));
      chk("tbl_done_once", 32'(done_seen), 32'd1);
`ifdef RAM_LOADER_CHECKSUM_EN
      chk("tbl_checksum", 32'(bus.checksum), 32'(vecs[v].exp_sum));
`else
      chk("tbl_checksum", 32'(bus.checksum), 32'd0);
`endif
      bus.read_addr = vecs[v].chk_addr;
      #1;
      chk("tbl_read", 32'(bus.read_data), 32'(vecs[v].chk_data));
    end

    // Gapped stream with start pulses arriving while busy.
    run_load(3'd2, 4'd4, 64'h0000_0000_D4C3_B2A1, 40, 1);
    chk("gap_wr_count", 32'(bus.wr_count), 32'd4);
    chk("gap_done_once", 32'(done_seen), 32'd1);

    // Reset after two words: no done pulse, written words survive.
    bus.base_addr = 3'd1; bus.length = 4'd4; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h5A;
    tick();
    bus.in_data = 8'hA5;
    tick();
    done_seen = 0;
    rst = 1'b1; bus.in_data = 8'hFF;
    tick();
    rst = 1'b0; bus.in_valid = 1'b0;
    chk("abort_busy",     32'(bus.busy),     32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
    chk("abort_wr_count", 32'(bus.wr_count), 32'd0);
    repeat (3) tick();
    chk("abort_no_done", 32'(done_seen), 32'd0);
    bus.read_addr = 3'd1; #1;
    chk("abort_mem1", 32'(bus.read_data), 32'h5A);
    bus.read_addr = 3'd2; #1;
    chk("abort_mem2", 32'(bus.read_data), 32'hA5);

    for (int r = 0; r < 20; r++) begin
      run_load(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
               {$urandom, $urandom}, 30, 1);
      chk("rand_done_once", 32'(done_seen), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
